// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single lower-memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; default build gives D priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              d_blocked
);

  typedef enum logic [1:0] {IDLE, I_SERVE, D_SERVE} state_e;

  state_e            state_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              d_req, grant_d;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant_d_q: 1 = D was granted last, 0 = I (reset value)
  logic last_grant_d_q;
  assign grant_d = d_req && !(i_read && last_grant_d_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_d_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // A combined read+write from D is a writeback, so write wins.
          if (grant_d) begin
            state_q     <= D_SERVE;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_write_q <= d_write;
            mem_read_q  <= !d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_d_q <= 1'b1;
`endif
          end else if (i_read) begin
            state_q     <= I_SERVE;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_d_q <= 1'b0;
`endif
          end
        end
        I_SERVE, D_SERVE: begin
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_resp    = (state_q == I_SERVE) && mem_resp;
  assign d_resp    = (state_q == D_SERVE) && mem_resp;
  assign d_blocked = (state_q == I_SERVE) && d_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every
// output each cycle; a directed prologue pins the model with literal values.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0, rst;
  logic              i_read, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write, d_blocked;
  logic [ADDR_W-1:0] mem_addr;

  int errors = 0, checks = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .d_blocked(d_blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---- reference model: who owns memory and what it asked for ----
  logic              m_busy, m_own_d, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              m_last_d;
  function automatic bit pick_d(bit ir, bit dr, bit lastd);
    if (ir && dr) return lastd ? 1'b0 : 1'b1;
    return dr;
  endfunction
`else
  function automatic bit pick_d(bit ir, bit dr);
    if (dr) return 1'b1;
    return ir ? 1'b0 : 1'b0;
  endfunction
`endif

  wire dreq = d_read | d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  wire winner_d = pick_d(i_read, dreq, m_last_d);
`else
  wire winner_d = pick_d(i_read, dreq);
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_own_d <= 1'b0; m_wr <= 1'b0;
      m_addr <= '0; m_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last_d <= 1'b0;
`endif
    end else if (!m_busy) begin
      if (i_read || dreq) begin
        m_busy  <= 1'b1;
        m_own_d <= winner_d;
        m_wr    <= winner_d ? d_write : 1'b0;
        m_addr  <= winner_d ? d_addr : i_addr;
        m_wdata <= winner_d ? d_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_last_d <= winner_d;
`endif
      end
    end else if (mem_resp) begin
      m_busy <= 1'b0;
    end
  end

  // ---- per-cycle compare against the model ----
  logic s_i_resp = 1'b0, s_d_resp = 1'b0;
  always @(negedge clk) begin
    s_i_resp = i_resp;
    s_d_resp = d_resp;
    chk("mem_read",  {255'd0, mem_read},  {255'd0, m_busy && !m_wr});
    chk("mem_write", {255'd0, mem_write}, {255'd0, m_busy && m_wr});
    chk("i_resp",    {255'd0, i_resp},    {255'd0, m_busy && !m_own_d && mem_resp});
    chk("d_resp",    {255'd0, d_resp},    {255'd0, m_busy && m_own_d && mem_resp});
    chk("d_blocked", {255'd0, d_blocked}, {255'd0, m_busy && !m_own_d && (d_read || d_write)});
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
    if (m_busy) chk("mem_addr", {224'd0, mem_addr}, {224'd0, m_addr});
    if (m_busy && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    if (!rst) begin
      chk("rst_addr", {224'd0, mem_addr}, '0);
      chk("rst_wdata", mem_wdata, '0);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [LINE_W-1:0] RD_PAT = {8{32'hC0DE_1234}};
  localparam logic [LINE_W-1:0] A5_PAT = {32{8'hA5}};

  initial begin
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = RD_PAT;
    repeat (3) step();
    at_neg();
    chk("reset_mem_read", {255'd0, mem_read}, '0);
    chk("reset_blocked", {255'd0, d_blocked}, '0);
    step(); rst = 1'b1;

    // stray mem_resp while idle
    step(); mem_resp = 1'b1;
    at_neg();
    chk("idle_resp", {254'd0, i_resp, d_resp}, '0);
    chk("idle_mem", {254'd0, mem_read, mem_write}, '0);
    chk("idle_addr", {224'd0, mem_addr}, '0);
    step(); mem_resp = 1'b0;

    // I line fill
    step(); i_read = 1'b1; i_addr = 32'h0000_1000;
    at_neg(); chk("i_lat0", {255'd0, mem_read}, '0);
    step(); at_neg();
    chk("i_mem_read", {255'd0, mem_read}, 256'd1);
    chk("i_mem_addr", {224'd0, mem_addr}, 256'h1000);
    repeat (3) step();
    step(); mem_resp = 1'b1;
    at_neg();
    chk("i_resp_lit", {255'd0, i_resp}, 256'd1);
    chk("i_rdata_lit", i_rdata, RD_PAT);
    chk("i_no_dresp", {255'd0, d_resp}, '0);
    step(); mem_resp = 1'b0; i_read = 1'b0;
    at_neg(); chk("i_done", {254'd0, mem_read, i_resp}, '0);

    // D writeback
    step(); d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = A5_PAT;
    at_neg(); chk("d_lat0", {255'd0, mem_write}, '0);
    step(); at_neg();
    chk("d_mem_write", {254'd0, mem_write, mem_read}, 256'd2);
    chk("d_mem_addr", {224'd0, mem_addr}, 256'h8000_0040);
    chk("d_mem_wdata", mem_wdata, A5_PAT);
    step(); step(); mem_resp = 1'b1;
    at_neg(); chk("d_resp_lit", {254'd0, d_resp, mem_write}, 256'd3);
    step(); mem_resp = 1'b0; d_write = 1'b0;
    at_neg(); chk("d_done", {254'd0, d_resp, mem_write}, '0);

    // simultaneous I and D reads
    step(); i_read = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_addr = 32'h200;
    step(); at_neg();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_first", {224'd0, mem_addr}, 256'h100);
`else
    chk("tie_first", {224'd0, mem_addr}, 256'h200);
`endif
    step(); mem_resp = 1'b1;
    step(); mem_resp = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    i_read = 1'b0;
`else
    d_read = 1'b0;
`endif
    at_neg(); chk("tie_bubble", {255'd0, mem_read}, '0);
    step(); at_neg();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_second", {224'd0, mem_addr}, 256'h200);
`else
    chk("tie_second", {224'd0, mem_addr}, 256'h100);
`endif
    step(); mem_resp = 1'b1;
    step(); mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;

    // D blocked behind I
    step(); i_read = 1'b1; i_addr = 32'h300;
    step(); d_read = 1'b1; d_addr = 32'h400;
    at_neg(); chk("blocked_a", {255'd0, d_blocked}, 256'd1);
    step(); mem_resp = 1'b1;
    at_neg(); chk("blocked_resp", {254'd0, d_blocked, i_resp}, 256'd3);
    step(); mem_resp = 1'b0; i_read = 1'b0;
    at_neg(); chk("blocked_idle", {254'd0, d_blocked, mem_read}, '0);
    step(); at_neg(); chk("blocked_grant", {224'd0, mem_addr}, 256'h400);
    step(); mem_resp = 1'b1;
    step(); mem_resp = 1'b0; d_read = 1'b0;

    // async reset mid D_SERVE
    step(); d_write = 1'b1; d_addr = 32'h500; d_wdata = rnd_line();
    step(); at_neg(); chk("pre_rst_write", {255'd0, mem_write}, 256'd1);
    step(); rst = 1'b0; #1;
    chk("async_rst_write", {254'd0, mem_write, d_resp}, '0);
    d_write = 1'b0;
    step(); step(); rst = 1'b1;
    step(); at_neg(); chk("post_rst_idle", {254'd0, mem_read, mem_write}, '0);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        #1; chk("rand_async_rst", {254'd0, mem_read, mem_write}, '0);
        step(); step(); rst = 1'b1;
        continue;
      end
      if (s_i_resp) i_read = 1'b0;
      else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1'b1; i_addr = $urandom;
      end else if (i_read && $urandom_range(0, 49) == 0) i_read = 1'b0;
      if (s_d_resp) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: begin d_read = 1'b1; d_write = 1'b0; end
          1: begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_addr = $urandom; d_wdata = rnd_line();
      end else if ((d_read || d_write) && $urandom_range(0, 49) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
      mem_rdata = rnd_line();
      if (mem_read || mem_write) mem_resp = ($urandom_range(0, 2) == 0);
      else mem_resp = ($urandom_range(0, 9) == 0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the memory address width.
REQ-002 SHALL have parameter LINE_W, default 256, the cacheline width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports i_read (in, 1), i_addr (in, ADDR_W), i_rdata (out, LINE_W), i_resp (out, 1): the instruction-cache line-fill port.
REQ-006 SHALL have ports d_read (in, 1), d_write (in, 1), d_addr (in, ADDR_W), d_wdata (in, LINE_W), d_rdata (out, LINE_W), d_resp (out, 1): the data-cache fill/writeback port.
REQ-007 SHALL have ports mem_read (out, 1), mem_write (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, LINE_W), mem_rdata (in, LINE_W), mem_resp (in, 1): the shared lower-memory port.
REQ-008 SHALL have port d_blocked, output, 1 bit: a D request is pending while an I transaction owns memory.

Function
REQ-009 SHALL implement FSM states IDLE, I_SERVE, D_SERVE.
REQ-010 In IDLE, SHALL grant on the rising edge after a request is sampled, latching the winner's address, wdata and read/write type, then enter I_SERVE or D_SERVE.
REQ-011 In IDLE, SHALL drive mem_read=0 and mem_write=0; no request reaches memory in the cycle it is first asserted (1-cycle grant latency).
REQ-012 In a SERVE state, SHALL drive mem_addr, mem_wdata, mem_read and mem_write from the latched values, holding them constant until mem_resp.
REQ-013 On mem_resp=1 in a SERVE state, SHALL pulse the owner's resp for exactly that cycle, deassert mem_read and mem_write next cycle, and return to IDLE.
REQ-014 SHALL pass i_rdata and d_rdata combinationally from mem_rdata at all times; the data is valid only while the matching resp is high.
REQ-015 SHALL allow only one memory transaction at a time, with one IDLE bubble cycle between back-to-back transactions.
REQ-016 Requesters SHALL hold their request and its inputs until resp; a request dropped mid-transaction SHALL NOT abort memory, and resp SHALL still pulse.
REQ-017 SHALL treat d_read=1 with d_write=1 as a write (writeback) transaction.
REQ-018 SHALL never assert i_resp and d_resp in the same cycle, and SHALL never assert mem_read and mem_write together.
REQ-019 SHALL assert d_blocked combinationally when state=I_SERVE and (d_read or d_write); otherwise d_blocked=0.
REQ-020 SHALL resolve simultaneous I and D requests in IDLE per REQ-026/REQ-027.
REQ-021 SHALL ignore mem_resp while in IDLE, with no resp pulse and no state change.

Reset
REQ-022 While rst=0, SHALL hold state at IDLE and force mem_read=0, mem_write=0, i_resp=0, d_resp=0, d_blocked=0, mem_addr=0, mem_wdata=0, and last_grant=I.
REQ-023 A reset assertion mid-transaction SHALL immediately deassert mem_read and mem_write and drop the transaction, with no resp issued.
REQ-024 After rst rises, SHALL consider the first requests at the next rising edge.

Configuration
REQ-025 SHALL support macro MEM_ARB_ROUND_ROBIN_EN.
REQ-026 With MEM_ARB_ROUND_ROBIN_EN defined, SHALL keep a last_grant register updated on each grant and, on simultaneous requests, grant the requester not granted last.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN, SHALL always grant D over I on simultaneous requests, and last_grant SHALL be absent.

Verification
REQ-028 i_read=1, i_addr=0x0000_1000, mem_resp after 5 cycles -> mem_read=1 with mem_addr=0x1000 from cycle 1; i_resp=1 for 1 cycle with i_rdata=mem_rdata; d_resp stays 0.
REQ-029 d_write=1, d_addr=0x8000_0040, d_wdata=all-0xA5 -> mem_write=1 with the latched addr/data held until mem_resp; d_resp pulses once; mem_read stays 0.
REQ-030 i_read and d_read rise in the same cycle, both held, without the macro -> D is served first, then I after a 1-cycle IDLE bubble; with the macro and last_grant=D -> I is served first.
REQ-031 During I_SERVE, raise d_read -> d_blocked=1 until i_resp; D is granted on the edge after returning to IDLE.
REQ-032 Drive rst=0 mid-D_SERVE -> mem_write=0 asynchronously (before the next clk edge); no d_resp; state is IDLE after release.
REQ-033 Pulse mem_resp=1 while IDLE with no requests -> no resp is issued and all outputs remain 0.
